// File: rtl/out_port_bank_8x8.sv
// Output-port register bank: captures the selected demux output into one of
// eight port registers and scans the registers onto a one-hot display bus.
module out_port_bank_8x8 #(
    parameter int unsigned SCAN_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [2:0] sel,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic [7:0] in4,
    input  logic [7:0] in5,
    input  logic [7:0] in6,
    input  logic [7:0] in7,
    output logic [7:0] port0,
    output logic [7:0] port1,
    output logic [7:0] port2,
    output logic [7:0] port3,
    output logic [7:0] port4,
    output logic [7:0] port5,
    output logic [7:0] port6,
    output logic [7:0] port7,
    output logic [2:0] scan_idx,
    output logic [7:0] scan_en,
    output logic [7:0] scan_data,
    output logic [7:0] upd
);

    localparam int unsigned N_PORTS = 8;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned IDX_W   = 3;
    localparam int unsigned CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_scan_idx;
    logic [N_PORTS-1:0] r_scan_en;
    logic [DATA_W-1:0] r_scan_data;
    logic [N_PORTS-1:0] r_upd;
    logic [DATA_W-1:0] r_port [N_PORTS];

    logic [DATA_W-1:0] w_in_sel;
    logic              w_adv;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic [N_PORTS-1:0] w_upd_nxt;
    logic [DATA_W-1:0] w_port_nxt [N_PORTS];

    // Pick only the selected demux line so X on the others never reaches state
    always_comb begin
        w_in_sel = '0;
        case (sel)
            3'd0: w_in_sel = in0;
            3'd1: w_in_sel = in1;
            3'd2: w_in_sel = in2;
            3'd3: w_in_sel = in3;
            3'd4: w_in_sel = in4;
            3'd5: w_in_sel = in5;
            3'd6: w_in_sel = in6;
            3'd7: w_in_sel = in7;
            default: w_in_sel = '0;
        endcase
    end

    // Next-state for ports, scan position and updated flags
    always_comb begin
        w_adv     = (r_cnt == CNT_W'(SCAN_DIV - 1));
        w_idx_nxt = w_adv ? r_scan_idx + IDX_W'(1) : r_scan_idx;
        for (int k = 0; k < N_PORTS; k++) begin
            w_port_nxt[k] = r_port[k];
        end
        w_upd_nxt = r_upd;
        if (w_adv) begin
            w_upd_nxt[r_scan_idx] = 1'b0;
        end
        // A load after the clear so that set wins on a shared edge
        if (load) begin
            w_port_nxt[sel] = w_in_sel;
            w_upd_nxt[sel]  = 1'b1;
        end
    end

    // State registers; scan_data follows the next port/index so it tracks both in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_scan_idx  <= '0;
            r_scan_en   <= N_PORTS'(1);
            r_scan_data <= '0;
            r_upd       <= '0;
            for (int k = 0; k < N_PORTS; k++) begin
                r_port[k] <= '0;
            end
        end else begin
            r_cnt       <= w_adv ? '0 : r_cnt + CNT_W'(1);
            r_scan_idx  <= w_idx_nxt;
            r_scan_en   <= N_PORTS'(1) << w_idx_nxt;
            r_scan_data <= w_port_nxt[w_idx_nxt];
            r_upd       <= w_upd_nxt;
            for (int k = 0; k < N_PORTS; k++) begin
                r_port[k] <= w_port_nxt[k];
            end
        end
    end

    assign port0     = r_port[0];
    assign port1     = r_port[1];
    assign port2     = r_port[2];
    assign port3     = r_port[3];
    assign port4     = r_port[4];
    assign port5     = r_port[5];
    assign port6     = r_port[6];
    assign port7     = r_port[7];
    assign scan_idx  = r_scan_idx;
    assign scan_en   = r_scan_en;
    assign scan_data = r_scan_data;
    assign upd       = r_upd;

endmodule

// File: tb/tb_out_port_bank_8x8.sv
// Directed bench for out_port_bank_8x8: one instance with SCAN_DIV=4, one with SCAN_DIV=1,
// both driven by the same stimulus.
module tb_out_port_bank_8x8;

    logic       clk = 1'b0;
    logic       rst;
    logic       load;
    logic [2:0] sel;
    logic [7:0] din [8];
    logic [7:0] pa [8];
    logic [7:0] pb [8];
    logic [2:0] idx_a, idx_b;
    logic [7:0] en_a, en_b, sd_a, sd_b, upd_a, upd_b;

    int n_pass  = 0;
    int n_total = 0;
    int t       = 0;   // edges since the last reset edge
    logic [7:0] exp_p [8];

    always #5 clk = ~clk;

    out_port_bank_8x8 #(.SCAN_DIV(4)) u_a (
        .clk(clk), .rst(rst), .load(load), .sel(sel),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .port0(pa[0]), .port1(pa[1]), .port2(pa[2]), .port3(pa[3]),
        .port4(pa[4]), .port5(pa[5]), .port6(pa[6]), .port7(pa[7]),
        .scan_idx(idx_a), .scan_en(en_a), .scan_data(sd_a), .upd(upd_a)
    );

    out_port_bank_8x8 #(.SCAN_DIV(1)) u_b (
        .clk(clk), .rst(rst), .load(load), .sel(sel),
        .in0(din[0]), .in1(din[1]), .in2(din[2]), .in3(din[3]),
        .in4(din[4]), .in5(din[5]), .in6(din[6]), .in7(din[7]),
        .port0(pb[0]), .port1(pb[1]), .port2(pb[2]), .port3(pb[3]),
        .port4(pb[4]), .port5(pb[5]), .port6(pb[6]), .port7(pb[7]),
        .scan_idx(idx_b), .scan_en(en_b), .scan_data(sd_b), .upd(upd_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            t++;
        end
    endtask

    // Expected scan position: A advances every 4 edges, B every edge
    task automatic chk_scan();
        int ia, ib;
        ia = (t / 4) % 8;
        ib = t % 8;
        chk("idx_a", 8'(idx_a), 8'(ia));
        chk("en_a",  en_a,      8'(1 << ia));
        chk("idx_b", 8'(idx_b), 8'(ib));
        chk("en_b",  en_b,      8'(1 << ib));
    endtask

    task automatic chk_reset_state();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rst_pa%0d", k), pa[k], 8'h00);
            chk($sformatf("rst_pb%0d", k), pb[k], 8'h00);
        end
        chk("rst_upd_a", upd_a, 8'h00);
        chk("rst_upd_b", upd_b, 8'h00);
        chk("rst_sd_a", sd_a, 8'h00);
        chk("rst_sd_b", sd_b, 8'h00);
        chk_scan();
    endtask

    initial begin
        rst  = 1'b1;
        load = 1'b0;
        sel  = 3'd0;
        for (int k = 0; k < 8; k++) din[k] = 8'h00;
        tick(1);
        t = 0;
        chk_reset_state();
        rst = 1'b0;

        // Idle rotation: full cycle of A (32 edges)
        for (int i = 0; i < 32; i++) begin
            tick(1);
            chk_scan();
            chk("idle_sd_a", sd_a, 8'h00);
            chk("idle_sd_b", sd_b, 8'h00);
            chk("idle_upd_a", upd_a, 8'h00);
        end

        // Load port 3 with all other demux lines X
        for (int k = 0; k < 8; k++) din[k] = 8'hxx;
        din[3] = 8'hA5; sel = 3'd3; load = 1'b1;
        tick(1);                                   // t=33
        load = 1'b0;
        for (int k = 0; k < 8; k++)
            chk($sformatf("ld3_pa%0d", k), pa[k], (k == 3) ? 8'hA5 : 8'h00);
        chk("ld3_upd", upd_a, 8'b0000_1000);
        chk("ld3_sd", sd_a, 8'h00);

        // Load port 0 while it is being scanned, mid-slot
        din[0] = 8'h3C; sel = 3'd0; load = 1'b1;
        tick(1);                                   // t=34
        load = 1'b0;
        chk("ld0_sd", sd_a, 8'h3C);
        chk("ld0_pa0", pa[0], 8'h3C);
        chk("ld0_upd", upd_a, 8'b0000_1001);
        tick(1);                                   // t=35
        chk("ld0_upd_hold", upd_a, 8'b0000_1001);
        tick(1);                                   // t=36, idx 0 -> 1
        chk("ld0_upd_clr", upd_a, 8'b0000_1000);
        chk("ld0_sd_p1", sd_a, 8'h00);
        chk_scan();

        // Load port 2 on the advance edge leaving index 2
        tick(7);                                   // t=43
        chk_scan();
        din[2] = 8'h11; sel = 3'd2; load = 1'b1;
        tick(1);                                   // t=44, idx 2 -> 3
        load = 1'b0;
        chk("ld2_pa2", pa[2], 8'h11);
        chk("ld2_upd_setwins", upd_a, 8'b0000_1100);
        chk("ld2_sd_p3", sd_a, 8'hA5);
        chk_scan();
        tick(4);                                   // t=48, leaves 3
        chk("upd3_clr", upd_a, 8'b0000_0100);
        tick(27);                                  // t=75, still on 2
        chk("upd2_hold", upd_a, 8'b0000_0100);
        chk("sd_p2", sd_a, 8'h11);
        tick(1);                                   // t=76, leaves 2
        chk("upd2_clr", upd_a, 8'h00);

        // Back-to-back loads to port 7, last write wins
        din[7] = 8'h01; sel = 3'd7; load = 1'b1;
        tick(1);                                   // t=77
        din[7] = 8'hFF;
        tick(1);                                   // t=78
        load = 1'b0;
        for (int k = 0; k < 8; k++) exp_p[k] = 8'h00;
        exp_p[0] = 8'h3C; exp_p[2] = 8'h11; exp_p[3] = 8'hA5; exp_p[7] = 8'hFF;
        for (int k = 0; k < 8; k++)
            chk($sformatf("ld7_pa%0d", k), pa[k], exp_p[k]);
        chk("ld7_upd", upd_a, 8'h80);
        tick(14);                                  // t=92, idx 7
        chk_scan();
        chk("sd_p7", sd_a, 8'hFF);
        tick(4);                                   // t=96, leaves 7
        chk("upd7_clr", upd_a, 8'h00);

        // Fill every port on consecutive edges
        for (int k = 0; k < 8; k++) begin
            din[k] = 8'(16 + k); sel = 3'(k); load = 1'b1;
            tick(1);
        end
        load = 1'b0;                               // t=104
        for (int k = 0; k < 8; k++)
            chk($sformatf("fill_pa%0d", k), pa[k], 8'(16 + k));

        // Reset mid-slot with a load pending: reset wins
        tick(1);                                   // t=105, mid-slot
        rst = 1'b1; din[5] = 8'hEE; sel = 3'd5; load = 1'b1;
        tick(1);
        t = 0;
        rst = 1'b0; load = 1'b0;
        chk_reset_state();

        // Scanning restarts with a full slot; B advances every edge
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk_scan();
            chk("post_sd_b", sd_b, 8'h00);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
